// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared types for the CPU command sequencer.
// Command bundle layout and sequencer FSM states.
package cpu_seq_pkg;

  localparam int CMD_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/cpu_seq_fifo.sv
// cpu_seq_fifo: synchronous command FIFO with a registered
// occupancy count; full/empty come straight from that count.
module cpu_seq_fifo
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// cpu_cmd_sequencer: queues host commands, strobes them into a CPU
// core and returns its result. SEQ_CMD_COUNT_EN adds cmd_count.
module cpu_cmd_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RESP_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_opcode,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic [7:0] cpu_opcode,
  output logic [7:0] cpu_addr,
  output logic [7:0] cpu_data,
  output logic       cpu_ena,
  input  logic [7:0] cpu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_opcode,
`ifdef SEQ_CMD_COUNT_EN
  output logic [7:0] cmd_count,
`endif
  output logic       busy
);

  localparam logic [3:0] LAT_LOAD = 4'(RESP_LAT - 1);

  seq_state_t state;
  seq_state_t next;
  cmd_t       push_cmd;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       load_cmd;
  logic       capture;
  logic       rsp_done;
  logic [3:0] wait_cnt;

  assign push_cmd  = {cmd_opcode, cmd_addr, cmd_data};
  assign cmd_ready = !fifo_full;
  assign cpu_ena   = (state == ISSUE);
  assign busy      = (state != IDLE) || !fifo_empty;

  cpu_seq_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid),
    .pop  (fifo_pop),
    .wdata(push_cmd),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    fifo_pop = 1'b0;
    load_cmd = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next     = ISSUE;
          fifo_pop = 1'b1;
          load_cmd = 1'b1;
        end
      end
      ISSUE: next = WAIT;
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          next    = RESP;
          capture = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          // Chain straight into the next command when one is queued.
          if (!fifo_empty) begin
            next     = ISSUE;
            fifo_pop = 1'b1;
            load_cmd = 1'b1;
          end else begin
            next = IDLE;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_opcode <= '0;
      cpu_addr   <= '0;
      cpu_data   <= '0;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_opcode <= '0;
    end else begin
      if (load_cmd) begin
        cpu_opcode <= head.opcode;
        cpu_addr   <= head.addr;
        cpu_data   <= head.data;
      end
      if (state == ISSUE)
        wait_cnt <= LAT_LOAD;
      else if (state == WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_data   <= cpu_result;
        rsp_opcode <= cpu_opcode;
      end else if (rsp_done) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef SEQ_CMD_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cmd_count <= '0;
    else if (rsp_done) cmd_count <= cmd_count + 8'd1;
  end
`endif

endmodule
